// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic-light sequence monitor.
// Light codes, monitor FSM encoding, and err_sticky bit positions.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED   = 2'b00,
        GREEN = 2'b01,
        YEL   = 2'b10,
        ILL   = 2'b11
    } light_t;

    // Low two bits match the light code so state_o is a plain slice; bit 2 marks SYNC.
    typedef enum logic [2:0] {
        ST_RED   = 3'b000,
        ST_GREEN = 3'b001,
        ST_YEL   = 3'b010,
        ST_SYNC  = 3'b100
    } mon_state_t;

    localparam int ERR_W     = 4;
    localparam int ERR_CODE  = 0;
    localparam int ERR_SEQ   = 1;
    localparam int ERR_SHORT = 2;
    localparam int ERR_LONG  = 3;

    function automatic light_t next_light(input light_t cur);
        case (cur)
            RED:     next_light = GREEN;
            GREEN:   next_light = YEL;
            default: next_light = RED;
        endcase
    endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Saturating dwell counter: clear, load-to-1 and increment, with an at-MAX_DWELL
// compare on the current count.
module tl_dwell_counter #(
    parameter int CNT_W     = 8,
    parameter int MAX_DWELL = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_max_o
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_DWELL);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q == MAX_VAL);

endmodule

// File: rtl/traffic_light_monitor.sv
// Runtime safety monitor for the 2-bit traffic-light code bus: locks onto
// Red->Green->Yellow->Red, measures phase dwell and reports sequencing errors.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 200,
    parameter int CNT_W     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           light_in,
    input  logic                 light_valid,
    input  logic                 clear,
    output logic                 locked,
    output logic [1:0]           state_o,
    output logic [CNT_W-1:0]     dwell_o,
    output logic                 phase_done,
    output logic                 err_code,
    output logic                 err_seq,
    output logic                 err_short,
    output logic                 err_long,
    output logic [ERR_W-1:0]     err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = '1;

    mon_state_t           state_q, state_d;
    logic                 phase_done_q, phase_done_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [ERR_W-1:0]     sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] count_q, count_d, count_base;
    logic                 cnt_clr, cnt_load, cnt_inc, at_max;
    light_t               code, cur_light;

    tl_dwell_counter #(
        .CNT_W     (CNT_W),
        .MAX_DWELL (MAX_DWELL)
    ) u_dwell (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (cnt_clr),
        .load_i   (cnt_load),
        .inc_i    (cnt_inc),
        .cnt_o    (dwell_o),
        .at_max_o (at_max)
    );

    assign code      = light_t'(light_in);
    assign cur_light = light_t'(state_q[1:0]);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        phase_done_d = 1'b0;
        err_d        = '0;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;

        if (light_valid) begin
            if (state_q == ST_SYNC) begin
                if (code == ILL) begin
                    err_d[ERR_CODE] = 1'b1;
                end else if (code == RED) begin
                    state_d  = ST_RED;
                    cnt_load = 1'b1;
                end
            end else if (code == ILL) begin
                err_d[ERR_CODE] = 1'b1;
                state_d         = ST_SYNC;
                cnt_clr         = 1'b1;
            end else if (code == cur_light) begin
                cnt_inc         = 1'b1;
                err_d[ERR_LONG] = at_max;
            end else if (code == next_light(cur_light)) begin
                state_d          = mon_state_t'({1'b0, code});
                cnt_load         = 1'b1;
                phase_done_d     = 1'b1;
                err_d[ERR_SHORT] = (dwell_o < CNT_W'(MIN_DWELL));
            end else begin
                // A stray RED is itself a valid lock point, so re-enter RED directly.
                err_d[ERR_SEQ] = 1'b1;
                if (code == RED) begin
                    state_d  = ST_RED;
                    cnt_load = 1'b1;
                end else begin
                    state_d = ST_SYNC;
                    cnt_clr = 1'b1;
                end
            end
        end

        sticky_d   = (clear ? '0 : sticky_q) | err_d;
        count_base = clear ? '0 : count_q;
        count_d    = count_base;
        if ((|err_d) && (count_base != ERR_CNT_SAT)) begin
            count_d = count_base + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SYNC;
            phase_done_q <= 1'b0;
            err_q        <= '0;
            sticky_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            phase_done_q <= phase_done_d;
            err_q        <= err_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
        end
    end

    assign locked     = (state_q != ST_SYNC);
    assign state_o    = state_q[1:0];
    assign phase_done = phase_done_q;
    assign err_code   = err_q[ERR_CODE];
    assign err_seq    = err_q[ERR_SEQ];
    assign err_short  = err_q[ERR_SHORT];
    assign err_long   = err_q[ERR_LONG];
    assign err_sticky = sticky_q;
    assign err_count  = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: two monitor instances (different dwell limits) see the same
// stimulus; a behavioural model queues expected outputs that are checked after each edge.
module tb_traffic_light_monitor;

    localparam int CNT_W     = 8;
    localparam int ERR_CNT_W = 8;
    localparam int A_MIN = 1, A_MAX = 4;
    localparam int B_MIN = 3, B_MAX = 200;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] light_in = 2'b00;
    logic       light_valid = 1'b0;
    logic       clear = 1'b0;

    logic                 a_locked, b_locked, a_pd, b_pd;
    logic [1:0]           a_state, b_state;
    logic [CNT_W-1:0]     a_dwell, b_dwell;
    logic                 a_ec, a_es, a_esh, a_el, b_ec, b_es, b_esh, b_el;
    logic [3:0]           a_sticky, b_sticky;
    logic [ERR_CNT_W-1:0] a_count, b_count;

    always #5 clk = ~clk;

    traffic_light_monitor #(.MIN_DWELL(A_MIN), .MAX_DWELL(A_MAX), .CNT_W(CNT_W), .ERR_CNT_W(ERR_CNT_W)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .light_in(light_in), .light_valid(light_valid), .clear(clear),
        .locked(a_locked), .state_o(a_state), .dwell_o(a_dwell), .phase_done(a_pd),
        .err_code(a_ec), .err_seq(a_es), .err_short(a_esh), .err_long(a_el),
        .err_sticky(a_sticky), .err_count(a_count)
    );

    traffic_light_monitor #(.MIN_DWELL(B_MIN), .MAX_DWELL(B_MAX), .CNT_W(CNT_W), .ERR_CNT_W(ERR_CNT_W)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .light_in(light_in), .light_valid(light_valid), .clear(clear),
        .locked(b_locked), .state_o(b_state), .dwell_o(b_dwell), .phase_done(b_pd),
        .err_code(b_ec), .err_seq(b_es), .err_short(b_esh), .err_long(b_el),
        .err_sticky(b_sticky), .err_count(b_count)
    );

    typedef struct {
        logic       locked;
        logic [1:0] st;
        int         dwell;
        logic       pd;
        logic [3:0] pulse;   // {long, short, seq, code}
        logic [3:0] sticky;
        int         count;
    } mstate_t;

    int n_checks = 0;
    int n_errors = 0;
    mstate_t ma, mb, m_reset;
    mstate_t exp_a_q[$];
    mstate_t exp_b_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] succ(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b01;
            2'b01:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic v, input logic [1:0] code,
                                           input logic clr, input int min_d, input int max_d);
        mstate_t n;
        n = s;
        n.pd = 1'b0;
        n.pulse = 4'b0000;
        if (v) begin
            if (!s.locked) begin
                if (code == 2'b11) n.pulse[0] = 1'b1;
                else if (code == 2'b00) begin
                    n.locked = 1'b1; n.st = 2'b00; n.dwell = 1;
                end
            end else if (code == 2'b11) begin
                n.pulse[0] = 1'b1; n.locked = 1'b0; n.st = 2'b00; n.dwell = 0;
            end else if (code == s.st) begin
                if (s.dwell == max_d) n.pulse[3] = 1'b1;
                n.dwell = (s.dwell >= 255) ? 255 : s.dwell + 1;
            end else if (code == succ(s.st)) begin
                if (s.dwell < min_d) n.pulse[2] = 1'b1;
                n.st = code; n.dwell = 1; n.pd = 1'b1;
            end else begin
                n.pulse[1] = 1'b1;
                if (code == 2'b00) begin
                    n.st = 2'b00; n.dwell = 1;
                end else begin
                    n.locked = 1'b0; n.st = 2'b00; n.dwell = 0;
                end
            end
        end
        n.sticky = (clr ? 4'b0000 : s.sticky) | n.pulse;
        if (clr) n.count = (n.pulse != 4'b0000) ? 1 : 0;
        else if ((n.pulse != 4'b0000) && (s.count < 255)) n.count = s.count + 1;
        return n;
    endfunction

    task automatic compare(input string who, input mstate_t e, input logic locked, input logic [1:0] st,
                           input logic [7:0] dwell, input logic pd, input logic [3:0] pulse,
                           input logic [3:0] sticky, input logic [7:0] count);
        check({who, ".locked"}, 32'(locked), 32'(e.locked));
        check({who, ".state"},  32'(st),     32'(e.st));
        check({who, ".dwell"},  32'(dwell),  32'(e.dwell));
        check({who, ".phase_done"}, 32'(pd), 32'(e.pd));
        check({who, ".pulses"}, 32'(pulse),  32'(e.pulse));
        check({who, ".sticky"}, 32'(sticky), 32'(e.sticky));
        check({who, ".count"},  32'(count),  32'(e.count));
    endtask

    task automatic compare_both(input mstate_t ea, input mstate_t eb);
        compare("A", ea, a_locked, a_state, a_dwell, a_pd, {a_el, a_esh, a_es, a_ec}, a_sticky, a_count);
        compare("B", eb, b_locked, b_state, b_dwell, b_pd, {b_el, b_esh, b_es, b_ec}, b_sticky, b_count);
    endtask

    task automatic step(input logic v, input logic [1:0] code, input logic clr);
        light_valid = v;
        light_in    = code;
        clear       = clr;
        ma = model_step(ma, v, code, clr, A_MIN, A_MAX);
        mb = model_step(mb, v, code, clr, B_MIN, B_MAX);
        exp_a_q.push_back(ma);
        exp_b_q.push_back(mb);
        @(posedge clk);
        #1;
        compare_both(exp_a_q.pop_front(), exp_b_q.pop_front());
    endtask

    initial begin
        m_reset = '{locked: 1'b0, st: 2'b00, dwell: 0, pd: 1'b0, pulse: 4'b0000, sticky: 4'b0000, count: 0};
        ma = m_reset;
        mb = m_reset;

        #12;
        compare_both(m_reset, m_reset);
        @(negedge clk);
        reset_n = 1'b1;

        // Clean cycle R,G,Y,R,G
        step(1, 2'b00, 0); step(1, 2'b01, 0); step(1, 2'b10, 0); step(1, 2'b00, 0); step(1, 2'b01, 0);
        // Illegal code while in GREEN, GREEN stays unlocked, RED re-locks
        step(1, 2'b11, 0); step(1, 2'b01, 0); step(1, 2'b01, 0); step(1, 2'b00, 0);
        // RED -> YEL illegal; re-lock; GREEN -> RED re-enters RED directly
        step(1, 2'b10, 0); step(1, 2'b00, 0); step(1, 2'b01, 0); step(1, 2'b00, 0);
        // Short RED (2 samples) then full RED (3 samples) for the MIN_DWELL=3 instance
        step(1, 2'b00, 0); step(1, 2'b01, 0); step(1, 2'b10, 0);
        step(1, 2'b00, 0); step(1, 2'b00, 0); step(1, 2'b00, 0); step(1, 2'b01, 0);
        // GREEN x6 with valid toggling; MAX_DWELL=4 instance flags err_long on the 5th
        step(1, 2'b10, 0); step(1, 2'b00, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 2'b01, 0);
            step(0, 2'b01, 0);
        end
        check("A.dwell_hold", 32'(a_dwell), 32'd6);
        // Clear in the same cycle as an illegal code: the new error wins
        step(1, 2'b11, 1);
        check("A.clr_sticky", 32'(a_sticky), 32'h1);
        check("A.clr_count", 32'(a_count), 32'd1);
        // Lock into GREEN, then assert reset mid-phase
        step(1, 2'b00, 0); step(1, 2'b01, 0); step(1, 2'b01, 0);
        #2;
        reset_n = 1'b0;
        ma = m_reset;
        mb = m_reset;
        #1;
        compare_both(m_reset, m_reset);
        @(posedge clk);
        #1;
        compare_both(m_reset, m_reset);
        reset_n = 1'b1;
        // After release GREEN does not lock, RED does
        step(1, 2'b01, 0); step(1, 2'b00, 0);
        // Long RED: err_long fires once, dwell saturates at 255
        for (int i = 0; i < 260; i++) step(1, 2'b00, 0);
        check("A.dwell_sat", 32'(a_dwell), 32'd255);
        // Flood of illegal codes saturates err_count
        for (int i = 0; i < 260; i++) step(1, 2'b11, 0);
        check("B.count_sat", 32'(b_count), 32'd255);
        // Clear with no error and no valid sample
        step(0, 2'b00, 1);
        step(0, 2'b00, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side checker for the 2-bit traffic-light code bus. Codes: 00=Red, 01=Green, 10=Yellow; 11 is illegal.
- Samples the light code on qualified cycles and locks onto the Red->Green->Yellow->Red sequence.
- Measures dwell per phase and flags illegal codes, illegal transitions, short phases and overlong phases.
- Sits beside any light-sequence generator as a runtime safety monitor; its error outputs feed a status/interrupt block.

Parameters:
- MIN_DWELL, 1: minimum number of valid samples a phase must last before it may advance.
- MAX_DWELL, 200: maximum number of valid samples a phase may last. Must satisfy MAX_DWELL < 2^CNT_W - 1.
- CNT_W, 8: width of the dwell counter.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- light_in, input, 2: observed light code.
- light_valid, input, 1: light_in is sampled only on cycles where this is 1.
- clear, input, 1: synchronous clear of err_sticky and err_count.
- locked, output, 1: 1 when the monitor is tracking the sequence.
- state_o, output, 2: last accepted phase code; 00 while unlocked.
- dwell_o, output, CNT_W: valid samples in the current phase, saturating.
- phase_done, output, 1: one-cycle pulse on each legal phase advance.
- err_code, output, 1: one-cycle pulse, illegal code 11 sampled.
- err_seq, output, 1: one-cycle pulse, illegal successor sampled.
- err_short, output, 1: one-cycle pulse, phase left before MIN_DWELL.
- err_long, output, 1: one-cycle pulse, phase exceeded MAX_DWELL.
- err_sticky, output, 4: sticky error bits {long, short, seq, code}.
- err_count, output, ERR_CNT_W: saturating count of error events.

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, FSM in SYNC.
- All outputs are registered and reflect a sample one cycle after it is taken. Cycles with light_valid=0 change nothing: pulses are 0 and dwell holds.
- FSM states: SYNC, RED, GREEN, YEL. The state encoding equals the light code; locked=0 only in SYNC.
- SYNC:
  - Valid 00 -> RED, dwell_o=1.
  - Valid 01 or 10 -> stay in SYNC, no error.
  - Valid 11 -> err_code, stay in SYNC.
- Tracking state, same code sampled: dwell_o increments, saturating at 2^CNT_W-1. When dwell_o==MAX_DWELL before the increment, err_long pulses. This fires exactly once per phase.
- Tracking state, legal successor sampled (RED->GREEN, GREEN->YEL, YEL->RED): advance to that state, dwell_o=1, phase_done=1. If the old dwell_o < MIN_DWELL, err_short also pulses, but the advance still happens.
- Tracking state, illegal successor sampled: err_seq pulses and the FSM goes to SYNC (state_o=00, dwell_o=0). If that code is 00, the FSM instead re-enters RED directly with dwell_o=1.
- Tracking state, code 11 sampled: err_code pulses, FSM goes to SYNC. Code 11 takes priority over the sequence check.
- Several errors in one sample: each pulse asserts; err_count increments by 1 per sample, not per bit.
- err_sticky: next = (clear ? 0 : err_sticky) | new pulse bits. A new error in the same cycle as clear wins.
- err_count: next = clear ? (any_err ? 1 : 0) : saturating increment on any_err. Holds at 2^ERR_CNT_W-1.
- reset_n asserted mid-phase: immediate return to reset values. After release, the first valid 00 re-locks.

Decomposition:
- Package traffic_pkg holds:
  - light_t enum: RED=2'b00, GREEN=2'b01, YEL=2'b10, ILL=2'b11.
  - A next_light() function returning the legal successor.
  - ERR_* bit-index constants for err_sticky.
- One natural sub-module: tl_dwell_counter. It is a saturating counter with load-to-1, increment and clear, and provides an at-MAX compare output.
- FSM and error logic stay in the top level.

Test Plan:
- Reset, then valid RED,GREEN,YEL,RED,GREEN one per cycle (MIN_DWELL=1) -> locked=1 from the 1st sample; state_o follows 00,01,10,00,01; phase_done pulses 4 times; no errors; err_count=0.
- Locked in GREEN, sample 11 -> err_code=1 for one cycle, err_sticky=4'b0001, err_count=1, locked=0. Further GREEN samples stay unlocked; RED re-locks with dwell_o=1.
- Locked in RED, sample YEL -> err_seq pulse, err_sticky[1]=1, locked=0. Separately, locked in GREEN, sample RED -> err_seq pulse, state_o=00, locked=1.
- MIN_DWELL=3: RED,RED,GREEN -> err_short pulses with the GREEN sample, state_o=01, phase_done=1. RED x3 then GREEN -> no err_short.
- MAX_DWELL=4: GREEN x6 after lock, light_valid toggling 1/0 -> err_long pulses once, on the 5th valid sample. dwell_o reads 1..6 and does not advance on light_valid=0 cycles.
- clear=1 in the same cycle as an err_code sample -> err_sticky=4'b0001, err_count=1. reset_n low mid-GREEN -> all outputs 0 asynchronously.
